// File: rtl/neuron_pc_sched.sv
// neuron_pc_sched: sequential popcount neuron.
// A vector of CHUNKS 5-bit chunks is accepted in IDLE. In RUN, one chunk is
// popcounted per cycle and added to a 7-bit signed accumulator. The result is
// offered in DONE with a valid/ready handshake. abort cancels the operation
// from any state.
// Optional feature macro: NEURON_PC_TERNARY_EN. When defined, a second
// popcount over in_neg is subtracted each RUN cycle.

// Exact 5-input population count.
module neuron_pc_popcnt5 (
  input  logic [4:0] bits,
  output logic [2:0] cnt
);
  // Plain adder tree; the synthesiser maps this to a compact full-adder chain.
  always_comb begin
    cnt = 3'(bits[0]) + 3'(bits[1]) + 3'(bits[2]) + 3'(bits[3]) + 3'(bits[4]);
  end
endmodule

module neuron_pc_sched #(
  parameter int CHUNKS = 8,
  parameter int THRESH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5*CHUNKS-1:0]   in_pos,
  input  logic [5*CHUNKS-1:0]   in_neg,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_sum,
  output logic                  out_fire
);

  // The index must also hold CHUNKS itself. That value marks the extra RUN cycle
  // after the last chunk, so that DONE is entered CHUNKS+1 edges after the accept edge.
  localparam int              IW   = $clog2(CHUNKS + 1);
  localparam logic [IW-1:0]   LAST = IW'(CHUNKS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [5*CHUNKS-1:0]   pos_q, pos_d;
  logic signed [6:0]     acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;

  logic [4:0]            pos_chunk;
  logic [2:0]            pos_cnt;
  logic signed [6:0]     delta;

  // Select the chunk addressed by the index. This gives zero once the index is past the last chunk.
  always_comb begin
    pos_chunk = '0;
    for (int k = 0; k < CHUNKS; k++)
      if (idx_q == IW'(k)) pos_chunk = pos_q[5*k +: 5];
  end

  neuron_pc_popcnt5 u_pc_pos (.bits(pos_chunk), .cnt(pos_cnt));

`ifdef NEURON_PC_TERNARY_EN
  logic [5*CHUNKS-1:0]   neg_q, neg_d;
  logic [4:0]            neg_chunk;
  logic [2:0]            neg_cnt;

  // Matching chunk selection for the negative-weight vector.
  always_comb begin
    neg_chunk = '0;
    for (int k = 0; k < CHUNKS; k++)
      if (idx_q == IW'(k)) neg_chunk = neg_q[5*k +: 5];
  end

  neuron_pc_popcnt5 u_pc_neg (.bits(neg_chunk), .cnt(neg_cnt));

  // Signed per-chunk contribution, in the range -5..+5.
  always_comb begin
    delta = $signed({4'b0, pos_cnt}) - $signed({4'b0, neg_cnt});
  end

  // Capture the negative vector only on the accept edge.
  always_comb begin
    neg_d = neg_q;
    if (!abort && state_q == IDLE && in_valid) neg_d = in_neg;
  end

  // Negative vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= '0;
    else        neg_q <= neg_d;
  end
`else
  // in_neg has no effect in the binary build.
  logic unused_neg;
  assign unused_neg = ^in_neg;

  // Unsigned per-chunk contribution, in the range 0..5.
  always_comb begin
    delta = $signed({4'b0, pos_cnt});
  end
`endif

  // Next-state and datapath control. abort overrides every handshake.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          pos_d   = in_pos;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            acc_d = acc_q + delta;
            idx_d = idx_q + IW'(1);
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  // Signed compare of the registered sum against the threshold.
  assign out_fire  = (int'(acc_q) >= THRESH);

endmodule

// File: tb/tb_neuron_pc_sched.sv
// Directed, table-driven bench for neuron_pc_sched with default parameters.
// Define NEURON_PC_TERNARY_EN for both files to include the ternary vectors.
module tb_neuron_pc_sched;
  localparam int CHUNKS = 8;
  localparam int W      = 5*CHUNKS;

  logic          clk, rst_n;
  logic          in_valid, in_ready, abort, out_valid, out_ready, out_fire;
  logic [W-1:0]  in_pos, in_neg;
  logic [6:0]    out_sum;

  int total = 0;
  int bad   = 0;

  neuron_pc_sched #(.CHUNKS(CHUNKS), .THRESH(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_fire(out_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pos;
    logic [W-1:0] neg;
    logic [6:0]   sum;
    logic         fire;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one vector and hold it through the accept edge. Then scramble the
  // inputs so that any late sampling of in_pos/in_neg becomes visible.
  task automatic accept(input logic [W-1:0] p, input logic [W-1:0] n);
    in_pos   = p;
    in_neg   = n;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_pos   = ~p;
    in_neg   = ~n;
    chk("in_ready_low_after_accept", in_ready, 0);
  endtask

  // Count the edges from the accept edge until out_valid rises, with a bound.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  vec_t tv[10];
  int   nv;
  int   lat;
  logic seen;
  logic [6:0] held;

  initial begin
    in_valid = 0; abort = 0; out_ready = 1; in_pos = '0; in_neg = '0;
    rst_n = 0;
    #12;
    chk("reset_in_ready",  in_ready,  1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum",   out_sum,   0);
    chk("reset_out_fire",  out_fire,  0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    nv = 0;
    tv[nv++] = '{pos: {W{1'b1}},      neg: '0, sum: 7'd40, fire: 1'b1};
    tv[nv++] = '{pos: 40'h0F0F0F0F0F, neg: '0, sum: 7'd20, fire: 1'b1};
    tv[nv++] = '{pos: 40'h0F0F0F0F0E, neg: '0, sum: 7'd19, fire: 1'b0};
    tv[nv++] = '{pos: 40'h0,          neg: '0, sum: 7'd0,  fire: 1'b0};
    tv[nv++] = '{pos: 40'h0000000001, neg: '0, sum: 7'd1,  fire: 1'b0};
    tv[nv++] = '{pos: 40'h8000000000, neg: '0, sum: 7'd1,  fire: 1'b0};
    tv[nv++] = '{pos: 40'h00000003FF, neg: '0, sum: 7'd10, fire: 1'b0};
    tv[nv++] = '{pos: 40'hFFFFF00000, neg: '0, sum: 7'd20, fire: 1'b1};
`ifdef NEURON_PC_TERNARY_EN
    tv[nv++] = '{pos: '0,             neg: {W{1'b1}}, sum: 7'b1011000, fire: 1'b0};
    tv[nv++] = '{pos: {W{1'b1}},      neg: {W{1'b1}}, sum: 7'd0,       fire: 1'b0};
`endif

    // Table: latency, result, and return to IDLE with out_ready=1.
    for (int i = 0; i < nv; i++) begin
      accept(tv[i].pos, tv[i].neg);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, CHUNKS + 1);
      chk($sformatf("v%0d_sum", i),     out_sum,  tv[i].sum);
      chk($sformatf("v%0d_fire", i),    out_fire, tv[i].fire);
      @(posedge clk); #1;
      chk($sformatf("v%0d_in_ready_after", i),  in_ready,  1);
      chk($sformatf("v%0d_out_valid_after", i), out_valid, 0);
    end

    // Backpressure: hold the result in DONE for 5 cycles.
    out_ready = 0;
    accept(40'h0F0F0F0F0F, '0);
    wait_done(lat);
    chk("bp_latency", lat, CHUNKS + 1);
    held = out_sum;
    chk("bp_sum", held, 20);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_c%0d", c),    out_valid, 1);
      chk($sformatf("bp_sum_c%0d", c),      out_sum,   held);
      chk($sformatf("bp_in_ready_c%0d", c), in_ready,  0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_out_valid_drop", out_valid, 0);
    chk("bp_in_ready_rise",  in_ready,  1);

    // Abort during the 3rd RUN cycle. No result may appear afterwards.
    accept({W{1'b1}}, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready",  in_ready,  1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum_clear", out_sum,   0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    accept(40'h0000000007, '0);
    wait_done(lat);
    chk("post_abort_latency", lat, CHUNKS + 1);
    chk("post_abort_sum",     out_sum, 3);
    @(posedge clk); #1;

    // Reset mid-RUN: outputs return to reset values at once.
    accept({W{1'b1}}, '0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_sum",   out_sum,   0);
    chk("rst_mid_out_fire",  out_fire,  0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mid_no_valid", seen, 0);
    accept(40'h000000001F, '0);
    wait_done(lat);
    chk("post_rst_latency", lat, CHUNKS + 1);
    chk("post_rst_sum",     out_sum, 5);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neuron_pc_sched.md
NEURON_PC_SCHED -- requirements
Module: neuron_pc_sched

Interface
REQ-001 SHALL have parameter CHUNKS, default 8, meaning the number of 5-bit chunks per neuron input vector (range 1..12).
REQ-002 SHALL have parameter THRESH, default 20, meaning the signed firing threshold compared against the final sum.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  input vector valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a vector.
REQ-007 SHALL have port in_pos  input  5*CHUNKS  positive-weight activation bits; chunk k is bits [5k+4:5k].
REQ-008 SHALL have port in_neg  input  5*CHUNKS  negative-weight activation bits; used only when TERNARY_EN is defined.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_sum  output  7  two's-complement accumulated count.
REQ-013 SHALL have port out_fire  output  1  1 when out_sum >= THRESH (signed compare).

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE on in_valid&&in_ready, register in_pos and in_neg, clear the accumulator and chunk index, and enter RUN.
REQ-017 SHALL, in RUN, process exactly one chunk per cycle in ascending order k=0..CHUNKS-1 through a single shared exact 5-input popcount, adding its count (0..5) to the accumulator.
REQ-018 SHALL enter DONE in the cycle after chunk CHUNKS-1 is accumulated, so out_valid rises exactly CHUNKS+1 clock edges after the accepting edge.
REQ-019 SHALL hold out_sum and out_fire stable while in DONE with out_ready=0.
REQ-020 SHALL return to IDLE on out_valid&&out_ready, with in_ready=1 in the following cycle; no same-cycle bypass to a new input.
REQ-021 SHALL, on abort=1 in any state, enter IDLE at the next edge, discard the accumulator and produce no out_valid; abort has priority over all handshakes in the same cycle.
REQ-022 SHALL ignore in_pos and in_neg changes after acceptance; ignore in_valid outside IDLE.
REQ-023 SHALL size the accumulator at 7 bits signed; the range is -60..+60 with CHUNKS<=12, so no overflow occurs and no saturation logic is needed.
REQ-024 SHALL compute out_fire combinationally from the registered out_sum.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously enter IDLE with in_ready=1 after release, out_valid=0, out_sum=0, out_fire=0, accumulator=0 and chunk index=0.
REQ-026 SHALL, when reset asserts mid-RUN or in DONE, drop the operation with no result emitted.

Configuration
REQ-027 SHALL use macro NEURON_PC_TERNARY_EN.
REQ-028 SHALL, when NEURON_PC_TERNARY_EN is defined, use a second popcount on chunk k of in_neg and accumulate (popcount(pos_k) - popcount(neg_k)) per RUN cycle; the latency is unchanged.
REQ-029 SHALL, when NEURON_PC_TERNARY_EN is undefined, use only in_pos, leave in_neg unconnected internally, and produce out_sum in 0..5*CHUNKS with bit 6 always 0.

Verification
REQ-030 SHALL test: default parameters, in_pos all ones, out_ready=1 -> out_valid 9 edges after accept, out_sum=40, out_fire=1.
REQ-031 SHALL test: in_pos=0x0F0F0F0F0F (20 ones), no ternary -> out_sum=20, out_fire=1; then one bit fewer (19 ones) -> out_sum=19, out_fire=0.
REQ-032 SHALL test: out_ready held 0 for 5 cycles in DONE -> out_valid and out_sum stable; in_ready=0 throughout; in_ready=1 in the cycle after the out_ready handshake.
REQ-033 SHALL test: abort asserted on the 3rd RUN cycle -> IDLE next edge, no out_valid pulse; next vector computes a fresh sum uncorrupted by the aborted one.
REQ-034 SHALL test: rst_n pulsed low mid-RUN -> outputs immediately at reset values, in_ready=1 after release.
REQ-035 SHALL test, with NEURON_PC_TERNARY_EN: in_pos=0, in_neg all ones -> out_sum=-40 (7'b1011000), out_fire=0; in_pos all ones, in_neg equal to in_pos -> out_sum=0.
